// File: rtl/ia_addr_pkg.sv
// Shared types and constants for the IA address sequencer: FSM states,
// arbiter control encodings and default widths.
package ia_addr_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int BRAM_LAT   = 1;
  localparam int NUM_PHASES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [2:0] CTRL_HOLD   = 3'd0;
  localparam logic [2:0] CTRL_PHASE1 = 3'd1;
  localparam logic [2:0] CTRL_PHASE2 = 3'd2;
  localparam logic [2:0] CTRL_PHASE3 = 3'd3;
  localparam logic [2:0] CTRL_PHASE4 = 3'd4;

  // Arbiter select for a zero-based phase index.
  function automatic logic [2:0] phase_ctrl(input logic [1:0] phase);
    logic [2:0] ctrl;
    unique case (phase)
      2'd0:    ctrl = CTRL_PHASE1;
      2'd1:    ctrl = CTRL_PHASE2;
      2'd2:    ctrl = CTRL_PHASE3;
      default: ctrl = CTRL_PHASE4;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ia_latency_timer.sv
// Loadable down-counter that times the extra BRAM read-latency cycles
// spent in WAIT; expired is high once the remaining count reaches zero.
module ia_latency_timer #(
  parameter int bram_latency = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = (bram_latency > 2) ? $clog2(bram_latency) : 1;
  // WAIT lasts bram_latency-1 cycles, the last of which sees a zero count.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((bram_latency > 1) ? bram_latency - 2 : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ia_addr_sequencer.sv
// Walks the row/col address BRAMs over [first_addr..last_addr] (wrapping),
// stepping the arbiters through four phases per word with a valid/ready tag.
module ia_addr_sequencer
  import ia_addr_pkg::*;
#(
  parameter int ram_address_width = RAM_ADDR_W,
  parameter int bram_latency      = BRAM_LAT,
  parameter int num_phases        = NUM_PHASES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ram_address_width-1:0] first_addr,
  input  logic [ram_address_width-1:0] last_addr,
  output logic                         addr_bram_enable,
  output logic [ram_address_width-1:0] ram_address,
  output logic [2:0]                   arbiter_ctrl,
  output logic                         addr_valid,
  input  logic                         addr_ready,
  output logic [ram_address_width+1:0] addr_tag,
  output logic                         busy,
  output logic                         done
);

  localparam logic [1:0] LAST_PHASE = 2'(num_phases - 1);

  state_t                       state;
  logic [ram_address_width-1:0] addr_cnt;
  logic [ram_address_width-1:0] last_q;
  logic [1:0]                   phase;
  logic                         timer_load;
  logic                         timer_expired;

  assign timer_load = (state == ST_FETCH);

  ia_latency_timer #(.bram_latency(bram_latency)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    // Abort outranks everything else, including a same-cycle handshake.
    if (reset || (abort && state != ST_IDLE)) begin
      state            <= ST_IDLE;
      addr_cnt         <= '0;
      last_q           <= '0;
      phase            <= '0;
      addr_bram_enable <= 1'b0;
      ram_address      <= '0;
      arbiter_ctrl     <= CTRL_HOLD;
      addr_valid       <= 1'b0;
      addr_tag         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            addr_cnt         <= first_addr;
            last_q           <= last_addr;
            phase            <= '0;
            ram_address      <= first_addr;
            addr_bram_enable <= 1'b1;
            busy             <= 1'b1;
            state            <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bram_latency > 1) begin
            state <= ST_WAIT;
          end else begin
            arbiter_ctrl <= phase_ctrl(phase);
            state        <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (timer_expired) begin
            arbiter_ctrl <= phase_ctrl(phase);
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          arbiter_ctrl <= CTRL_HOLD;
          addr_valid   <= 1'b1;
          addr_tag     <= {addr_cnt, phase};
          state        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (addr_ready) begin
            addr_valid <= 1'b0;
            addr_tag   <= '0;
            if (phase != LAST_PHASE) begin
              phase        <= phase + 2'd1;
              arbiter_ctrl <= phase_ctrl(phase + 2'd1);
              state        <= ST_ISSUE;
            end else if (addr_cnt != last_q) begin
              addr_cnt    <= addr_cnt + 1'b1;
              ram_address <= addr_cnt + 1'b1;
              phase       <= '0;
              state       <= ST_FETCH;
            end else begin
              addr_bram_enable <= 1'b0;
              ram_address      <= '0;
              done             <= 1'b1;
              state            <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
